// File: rtl/simon_tone_sequencer.sv
// Simon pattern playback: sounds each stored color for NOTE_ON_CYCLES, then a silent gap.
// While idle, the player's held button drives the tone generator directly.
module simon_tone_sequencer #(
  parameter int unsigned NOTE_ON_CYCLES  = 25000000,
  parameter int unsigned NOTE_GAP_CYCLES = 12500000,
  parameter logic [17:0] TONE0 = 18'd190840,
  parameter logic [17:0] TONE1 = 18'd151685,
  parameter logic [17:0] TONE2 = 18'd127551,
  parameter logic [17:0] TONE3 = 18'd95556
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  seq_len,
  output logic [5:0]  step_addr,
  input  logic [1:0]  step_color,
  input  logic        press_valid,
  input  logic [1:0]  press_color,
  output logic [17:0] note,
  output logic        enable,
  output logic [1:0]  color_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAX_CYC = (NOTE_ON_CYCLES > NOTE_GAP_CYCLES) ? NOTE_ON_CYCLES
                                                                       : NOTE_GAP_CYCLES;
  // Counter runs 0..MAX_CYC-1, so clog2(MAX_CYC) bits never wraps.
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(NOTE_ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(NOTE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TONE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    color_q, color_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  function automatic logic [17:0] tone_of(input logic [1:0] c);
    case (c)
      2'd0:    tone_of = TONE0;
      2'd1:    tone_of = TONE1;
      2'd2:    tone_of = TONE2;
      default: tone_of = TONE3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      color_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    color_d = color_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (seq_len != 6'd0) begin
            len_d   = seq_len;
            addr_d  = 6'd0;
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        color_d = step_color;
        cnt_d   = '0;
        state_d = S_TONE;
      end
      S_TONE: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (addr_q == len_q - 6'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 6'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats every other transition, including the final done.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    step_addr = addr_q;
    enable    = 1'b0;
    note      = tone_of(color_q);
    color_out = color_q;
    case (state_q)
      S_IDLE: begin
        enable    = press_valid;
        note      = tone_of(press_color);
        color_out = press_color;
      end
      S_TONE:  enable = 1'b1;
      default: enable = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Bench for simon_tone_sequencer with short note timing: directed vectors, corner sequences,
// and random stimulus checked against a schedule-based playback model.
module tb_simon_tone_sequencer;

  localparam int ON       = 4;
  localparam int GAP      = 2;
  localparam int STEP_LEN = 1 + ON + GAP;

  logic        clk = 1'b0;
  logic        reset, start, abort, press_valid;
  logic [5:0]  seq_len, step_addr;
  logic [1:0]  step_color, press_color, color_out;
  logic [17:0] note;
  logic        enable, busy, done;

  logic [1:0]  pat [64];
  logic [17:0] tones [4];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  assign step_color = pat[step_addr];

  simon_tone_sequencer #(
    .NOTE_ON_CYCLES (ON),
    .NOTE_GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .seq_len    (seq_len),
    .step_addr  (step_addr),
    .step_color (step_color),
    .press_valid(press_valid),
    .press_color(press_color),
    .note       (note),
    .enable     (enable),
    .color_out  (color_out),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic        pv;
    logic [1:0]  pc;
    logic        exp_en;
    logic [17:0] exp_note;
    logic [1:0]  exp_col;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    press_valid = 1'b0; press_color = 2'd0; seq_len = 6'd0;
  endtask

  // Reset held with start/abort also high: reset must win.
  task automatic do_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; seq_len = 6'd3;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_addr", 0, step_addr, 0);
    chk("rst_enable", 0, enable, 0);
    idle_inputs();
    tick();
  endtask

  // Pattern {2,0,3}; race adds press/start/seq_len disturbances that must be ignored.
  task automatic run_std(input bit race);
    logic        exp_en;
    logic [17:0] exp_note;
    pat[0] = 2'd2; pat[1] = 2'd0; pat[2] = 2'd3;
    for (int c = 0; c <= 24; c++) begin
      start       = (c == 0) || (race && c == 6);
      seq_len     = (race && c >= 3) ? 6'd5 : 6'd3;
      press_valid = race && (c == 0 || c == 9);
      press_color = 2'd1;
      @(negedge clk);
      exp_en = (c >= 2 && c <= 5) || (c >= 9 && c <= 12) || (c >= 16 && c <= 19) || (race && c == 0);
      chk("std_enable", c, enable, exp_en);
      chk("std_busy", c, busy, (c >= 1 && c <= 21));
      chk("std_done", c, done, (c == 22));
      if (exp_en) begin
        exp_note = (c == 0) ? tones[1] : (c <= 5) ? tones[2] : (c <= 12) ? tones[0] : tones[3];
        chk("std_note", c, note, exp_note);
      end
      if (c >= 1 && c <= 21) chk("std_addr", c, step_addr, (c - 1) / STEP_LEN);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    tones[0] = 18'd190840; tones[1] = 18'd151685; tones[2] = 18'd127551; tones[3] = 18'd95556;
    for (int i = 0; i < 64; i++) pat[i] = 2'd0;
    vt[0] = '{1'b1, 2'd1, 1'b1, 18'd151685, 2'd1};
    vt[1] = '{1'b1, 2'd0, 1'b1, 18'd190840, 2'd0};
    vt[2] = '{1'b1, 2'd3, 1'b1, 18'd95556,  2'd3};
    vt[3] = '{1'b0, 2'd2, 1'b0, 18'd127551, 2'd2};
    vt[4] = '{1'b1, 2'd2, 1'b1, 18'd127551, 2'd2};
    vt[5] = '{1'b0, 2'd0, 1'b0, 18'd190840, 2'd0};
    vt[6] = '{1'b1, 2'd1, 1'b1, 18'd151685, 2'd1};
    vt[7] = '{1'b0, 2'd3, 1'b0, 18'd95556,  2'd3};
    idle_inputs();
    tick();
    do_reset();

    // Idle passthrough from the held button.
    for (int i = 0; i < 8; i++) begin
      press_valid = vt[i].pv; press_color = vt[i].pc;
      @(negedge clk);
      chk("tbl_enable", i, enable, vt[i].exp_en);
      chk("tbl_note", i, note, vt[i].exp_note);
      chk("tbl_color", i, color_out, vt[i].exp_col);
      chk("tbl_busy", i, busy, 0);
      chk("tbl_done", i, done, 0);
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      press_valid = 1'b1; press_color = 2'd1;
      @(negedge clk);
      chk("hold_enable", c, enable, 1);
      chk("hold_note", c, note, tones[1]);
      chk("hold_busy", c, busy, 0);
      chk("hold_done", c, done, 0);
      tick();
    end
    idle_inputs();

    run_std(1'b0);

    // Zero-length start: done pulse only.
    for (int c = 0; c <= 3; c++) begin
      start = (c == 0); seq_len = 6'd0;
      @(negedge clk);
      chk("zero_busy", c, busy, 0);
      chk("zero_enable", c, enable, 0);
      chk("zero_done", c, done, (c == 1));
      tick();
    end
    idle_inputs();

    // Abort mid-playback, then a fresh playback from step 0.
    pat[0] = 2'd2; pat[1] = 2'd0; pat[2] = 2'd3;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0); seq_len = 6'd3; abort = (c == 10);
      @(negedge clk);
      chk("abort_busy", c, busy, (c >= 1 && c <= 10));
      chk("abort_done", c, done, 0);
      if (c >= 11) chk("abort_enable", c, enable, 0);
      tick();
    end
    idle_inputs();
    run_std(1'b0);

    // Reset in the middle of playback.
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0); seq_len = 6'd3; reset = (c == 4);
      @(negedge clk);
      chk("mrst_done", c, done, 0);
      if (c >= 5) begin
        chk("mrst_busy", c, busy, 0);
        chk("mrst_enable", c, enable, 0);
        chk("mrst_addr", c, step_addr, 0);
        chk("mrst_color", c, color_out, 0);
        chk("mrst_note", c, note, tones[0]);
      end
      tick();
    end
    idle_inputs();

    run_std(1'b1);

    // Random stimulus against a schedule model: playback accepted at cycle t0 puts
    // step s phase p at cycle t0+1+s*STEP_LEN+p.
    do_reset();
    begin
      bit         m_act, m_done, m_addr_ok;
      int         m_t0, m_len, off, s, p;
      m_act = 0; m_done = 0; m_addr_ok = 1; m_t0 = 0; m_len = 0;
      for (int c = 0; c < 4000; c++) begin
        reset       = ($urandom_range(0, 249) == 0);
        abort       = ($urandom_range(0, 79) == 0);
        start       = ($urandom_range(0, 5) == 0);
        seq_len     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
        press_valid = 1'($urandom_range(0, 1));
        press_color = 2'($urandom_range(0, 3));
        if (!m_act) for (int i = 0; i < 64; i++) pat[i] = 2'($urandom_range(0, 3));
        @(negedge clk);
        off = 0;
        chk("rnd_busy", c, busy, m_act);
        chk("rnd_done", c, done, m_done);
        if (!m_act) begin
          chk("rnd_enable", c, enable, press_valid);
          chk("rnd_note", c, note, tones[press_color]);
          chk("rnd_color", c, color_out, press_color);
          if (m_addr_ok) chk("rnd_addr", c, step_addr, 0);
        end else begin
          off = c - m_t0 - 1;
          s = off / STEP_LEN;
          p = off % STEP_LEN;
          chk("rnd_addr", c, step_addr, s);
          if (p == 0) begin
            chk("rnd_enable", c, enable, 0);
          end else begin
            chk("rnd_enable", c, enable, (p <= ON));
            chk("rnd_note", c, note, tones[pat[s]]);
            chk("rnd_color", c, color_out, pat[s]);
          end
        end
        if (reset) begin
          m_act = 0; m_done = 0; m_addr_ok = 1;
        end else if (m_act) begin
          m_done = 0;
          if (abort) begin
            m_act = 0; m_addr_ok = 0;
          end else if (off == m_len * STEP_LEN - 1) begin
            m_act = 0; m_done = 1; m_addr_ok = 0;
          end
        end else if (start) begin
          if (seq_len != 6'd0) begin
            m_act = 1; m_t0 = c; m_len = seq_len; m_done = 0; m_addr_ok = 0;
          end else begin
            m_done = 1;
          end
        end else begin
          m_done = 0;
        end
        tick();
      end
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
